// File: rtl/vme_cmd_executor.sv
// vme_cmd_executor: responder end of the simulation command channel. Takes one
//   VME-style command word plus write data, runs a single register-bus read or
//   write, then returns a response word qualified by a one-cycle strobe.
// Ports: clk/rst (async active-high); start, vme_cmd_reg, vme_dat_reg_in,
//   vme_cmd_rd (ready level) from/to the command driver; vme_dat_wr,
//   vme_dat_reg_out response; bus_addr/bus_wdata/bus_rnw/bus_strobe/bus_ack/
//   bus_rdata register bus; busy status.
// Optional: define VME_TXN_COUNT_EN to put an 8-bit transaction count in
//   response bits [23:16]; without it those bits are 0.
module vme_cmd_executor #(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned GAP_CYC     = 2,
  parameter logic [31:0] CMD_MASK    = 32'h00A80000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] vme_cmd_reg,
  input  logic [31:0] vme_dat_reg_in,
  output logic        vme_cmd_rd,
  output logic        vme_dat_wr,
  output logic [31:0] vme_dat_reg_out,
  output logic [15:0] bus_addr,
  output logic [15:0] bus_wdata,
  output logic        bus_rnw,
  output logic        bus_strobe,
  input  logic        bus_ack,
  input  logic [15:0] bus_rdata,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DECODE  = 3'd1,
    STROBE  = 3'd2,
    RESPOND = 3'd3,
    HOLDOFF = 3'd4
  } state_t;

  localparam logic [16:0] TMO_LAST = 17'(TIMEOUT_CYC);
  // GAP_CYC=0 never enters HOLDOFF, so the clamp only keeps the constant legal.
  localparam logic [3:0]  GAP_LAST = (GAP_CYC > 0) ? 4'(GAP_CYC - 1) : 4'd0;

  state_t      state;
  logic [31:0] cmd_q;
  logic [15:0] dat_q;
  logic [15:0] tcnt;
  logic [3:0]  gcnt;
  logic [16:0] tcnt_next;
  logic        cmd_valid;
  logic [7:0]  cnt_field;
  logic        unused_dat_hi;

  assign unused_dat_hi = ^vme_dat_reg_in[31:16];

  // Every mask bit set and exactly one direction bit.
  assign cmd_valid = ((cmd_q & CMD_MASK) == CMD_MASK) && (cmd_q[25] ^ cmd_q[24]);
  assign tcnt_next = {1'b0, tcnt} + 17'd1;

`ifdef VME_TXN_COUNT_EN
  logic [7:0] txn_cnt;

  // Response word is built on entry to RESPOND with the pre-increment value;
  // the count advances while in RESPOND, so it wraps naturally at 255.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txn_cnt <= 8'd0;
    end else if (state == RESPOND) begin
      txn_cnt <= txn_cnt + 8'd1;
    end
  end

  assign cnt_field = txn_cnt;
`else
  assign cnt_field = 8'd0;
`endif

  function automatic logic [31:0] resp_word(input logic err, input logic tmo,
                                            input logic [7:0] cnt,
                                            input logic [15:0] d);
    return {err, tmo, 6'b0, cnt, d};
  endfunction

  // All outputs are registered and change together with the state, so the
  // response strobe lines up exactly with the single RESPOND cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      cmd_q           <= 32'd0;
      dat_q           <= 16'd0;
      tcnt            <= 16'd0;
      gcnt            <= 4'd0;
      vme_cmd_rd      <= 1'b1;
      vme_dat_wr      <= 1'b0;
      vme_dat_reg_out <= 32'd0;
      bus_addr        <= 16'd0;
      bus_wdata       <= 16'd0;
      bus_rnw         <= 1'b1;
      bus_strobe      <= 1'b0;
      busy            <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cmd_q      <= vme_cmd_reg;
            dat_q      <= vme_dat_reg_in[15:0];
            vme_cmd_rd <= 1'b0;
            busy       <= 1'b1;
            state      <= DECODE;
          end
        end

        DECODE: begin
          if (cmd_valid) begin
            bus_addr   <= cmd_q[15:0];
            bus_wdata  <= dat_q;
            bus_rnw    <= cmd_q[25];
            bus_strobe <= 1'b1;
            tcnt       <= 16'd0;
            state      <= STROBE;
          end else begin
            vme_dat_wr      <= 1'b1;
            vme_dat_reg_out <= resp_word(1'b1, 1'b0, cnt_field, 16'h0000);
            state           <= RESPOND;
          end
        end

        STROBE: begin
          // Ack is tested first so it wins over a simultaneous timeout.
          if (bus_ack) begin
            bus_strobe      <= 1'b0;
            vme_dat_wr      <= 1'b1;
            vme_dat_reg_out <= resp_word(1'b0, 1'b0, cnt_field,
                                         bus_rnw ? bus_rdata : bus_wdata);
            state           <= RESPOND;
          end else if (tcnt_next == TMO_LAST) begin
            bus_strobe      <= 1'b0;
            vme_dat_wr      <= 1'b1;
            vme_dat_reg_out <= resp_word(1'b0, 1'b1, cnt_field, 16'h0000);
            state           <= RESPOND;
          end else begin
            tcnt <= tcnt_next[15:0];
          end
        end

        RESPOND: begin
          vme_dat_wr <= 1'b0;
          if (GAP_CYC == 0) begin
            vme_cmd_rd <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end else begin
            gcnt  <= 4'd0;
            state <= HOLDOFF;
          end
        end

        HOLDOFF: begin
          if (gcnt == GAP_LAST) begin
            vme_cmd_rd <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end else begin
            gcnt <= gcnt + 4'd1;
          end
        end

        default: begin
          bus_strobe <= 1'b0;
          vme_dat_wr <= 1'b0;
          vme_cmd_rd <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vme_cmd_executor.sv
// tb_vme_cmd_executor: scenario tasks drive commands into vme_cmd_executor
//   while a negedge monitor plays the register bus and checks each response
//   word against a queue of expected words.
module tb_vme_cmd_executor;

  localparam int TMO = 8;
  localparam int GAP = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] vme_cmd_reg = 32'd0;
  logic [31:0] vme_dat_reg_in = 32'd0;
  logic        vme_cmd_rd;
  logic        vme_dat_wr;
  logic [31:0] vme_dat_reg_out;
  logic [15:0] bus_addr;
  logic [15:0] bus_wdata;
  logic        bus_rnw;
  logic        bus_strobe;
  logic        bus_ack = 1'b0;
  logic [15:0] bus_rdata = 16'd0;
  logic        busy;

  vme_cmd_executor #(.TIMEOUT_CYC(TMO), .GAP_CYC(GAP), .CMD_MASK(32'h00A80000)) dut (
    .clk(clk), .rst(rst), .start(start), .vme_cmd_reg(vme_cmd_reg),
    .vme_dat_reg_in(vme_dat_reg_in), .vme_cmd_rd(vme_cmd_rd), .vme_dat_wr(vme_dat_wr),
    .vme_dat_reg_out(vme_dat_reg_out), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rnw(bus_rnw), .bus_strobe(bus_strobe), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard and bus-responder state
  logic [31:0] exp_q[$];
  int          wr_times[$];
  logic [31:0] last_exp = 32'd0;
  int          resp_cnt = 0;
  int          wr_cyc = 0;
  int          ack_after_v = 1;
  logic [15:0] rdata_v = 16'd0;
  logic        ack_force = 1'b0;
  logic        strobe_prev = 1'b0;
  int          strobe_len = 0;
  int          strobe_total = 0;
  logic [15:0] cap_addr = 16'd0;
  logic [15:0] cap_wdata = 16'd0;
  logic        cap_rnw = 1'b0;
  int          low_run = 0;
  int          last_low_run = 0;
  logic [7:0]  txn_model = 8'd0;

  always @(negedge clk) begin
    if (vme_dat_wr) begin
      resp_cnt++;
      wr_cyc = cyc;
      wr_times.push_back(cyc);
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL resp_unexpected got=%h expected=none", vme_dat_reg_out);
      end else begin
        last_exp = exp_q.pop_front();
        if (vme_dat_reg_out !== last_exp)
          $display("FAIL resp_word got=%h expected=%h", vme_dat_reg_out, last_exp);
        else
          pass_cnt++;
      end
    end
    if (!vme_cmd_rd) begin
      low_run++;
    end else if (low_run > 0) begin
      last_low_run = low_run;
      low_run = 0;
    end
    if (bus_strobe) begin
      if (!strobe_prev) begin
        cap_addr = bus_addr;
        cap_wdata = bus_wdata;
        cap_rnw = bus_rnw;
        strobe_len = 0;
      end
      strobe_len++;
      strobe_total++;
      bus_ack = ack_force || (ack_after_v != 0 && strobe_len == ack_after_v);
    end else begin
      bus_ack = ack_force;
    end
    bus_rdata = rdata_v;
    strobe_prev = bus_strobe;
  end

  function automatic logic [31:0] mk_exp(input logic e, input logic t,
                                         input logic [7:0] c, input logic [15:0] d);
    logic [7:0] cf;
`ifdef VME_TXN_COUNT_EN
    cf = c;
`else
    cf = c & 8'h00;
`endif
    return {e, t, 6'b0, cf, d};
  endfunction

  // Issue one command and check response latency and ready return.
  // k = cycles from DECODE edge to the edge that raises vme_dat_wr.
  task automatic issue_cmd(input logic [31:0] cmd, input logic [31:0] data,
                           input int ack_after, input logic [15:0] rdata,
                           input logic e, input logic t, input logic [15:0] d16,
                           input int k, input string name);
    int r0;
    int t0;
    int i;
    i = 0;
    while (!vme_cmd_rd && i < 100) begin @(negedge clk); #1; i++; end
    if (!vme_cmd_rd) begin
      total_cnt++;
      $display("FAIL %s_ready_wait got=0 expected=1", name);
      return;
    end
    vme_cmd_reg = cmd;
    vme_dat_reg_in = data;
    ack_after_v = ack_after;
    rdata_v = rdata;
    exp_q.push_back(mk_exp(e, t, txn_model, d16));
    txn_model = txn_model + 8'd1;
    r0 = resp_cnt;
    start = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    start = 1'b0;
    i = 0;
    while (resp_cnt == r0 && i < 300) begin @(negedge clk); #1; i++; end
    total_cnt++;
    if (resp_cnt == r0)
      $display("FAIL %s_resp_timeout got=none expected=response", name);
    else if (wr_cyc - t0 != 1 + k)
      $display("FAIL %s_resp_latency got=%0d expected=%0d", name, wr_cyc - t0, 1 + k);
    else
      pass_cnt++;
    i = 0;
    while (!vme_cmd_rd && i < 100) begin @(negedge clk); #1; i++; end
    total_cnt++;
    if (cyc - t0 != 2 + k + GAP)
      $display("FAIL %s_ready_latency got=%0d expected=%0d", name, cyc - t0, 2 + k + GAP);
    else
      pass_cnt++;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    total_cnt++;
    if ({vme_cmd_rd, vme_dat_wr, bus_rnw, bus_strobe, busy} !== 5'b10100)
      $display("FAIL reset_ctrl got=%b expected=10100",
               {vme_cmd_rd, vme_dat_wr, bus_rnw, bus_strobe, busy});
    else pass_cnt++;
    total_cnt++;
    if ({vme_dat_reg_out, bus_addr, bus_wdata} !== 64'd0)
      $display("FAIL reset_data got=%h expected=0", {vme_dat_reg_out, bus_addr, bus_wdata});
    else pass_cnt++;
    rst = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic test_read();
    issue_cmd(32'h02A81234, 32'h0, 1, 16'hBEEF, 1'b0, 1'b0, 16'hBEEF, 1, "read");
    total_cnt++;
    if ({cap_addr, cap_rnw} !== {16'h1234, 1'b1})
      $display("FAIL read_bus got=%h/%b expected=1234/1", cap_addr, cap_rnw);
    else pass_cnt++;
    total_cnt++;
    if (strobe_len != 1) $display("FAIL read_strobe_len got=%0d expected=1", strobe_len);
    else pass_cnt++;
  endtask

  task automatic test_write();
    issue_cmd(32'h01A84000, 32'h00005A5A, 5, 16'hDEAD, 1'b0, 1'b0, 16'h5A5A, 5, "write");
    total_cnt++;
    if ({cap_addr, cap_wdata, cap_rnw} !== {16'h4000, 16'h5A5A, 1'b0})
      $display("FAIL write_bus got=%h/%h/%b expected=4000/5a5a/0", cap_addr, cap_wdata, cap_rnw);
    else pass_cnt++;
    total_cnt++;
    if (strobe_len != 5) $display("FAIL write_strobe_len got=%0d expected=5", strobe_len);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    issue_cmd(32'h02A80042, 32'h0, 0, 16'h7777, 1'b0, 1'b1, 16'h0000, TMO, "timeout");
    total_cnt++;
    if (strobe_len != TMO) $display("FAIL timeout_strobe_len got=%0d expected=%0d", strobe_len, TMO);
    else pass_cnt++;
  endtask

  task automatic test_invalid();
    int s0;
    s0 = strobe_total;
    issue_cmd(32'h03001234, 32'h0, 1, 16'h1111, 1'b1, 1'b0, 16'h0000, 0, "invalid");
    total_cnt++;
    if (strobe_total != s0)
      $display("FAIL invalid_no_strobe got=%0d expected=0", strobe_total - s0);
    else pass_cnt++;
  endtask

  task automatic test_hold();
    repeat (6) @(negedge clk);
    #1;
    total_cnt++;
    if (vme_dat_reg_out !== last_exp)
      $display("FAIL resp_hold got=%h expected=%h", vme_dat_reg_out, last_exp);
    else pass_cnt++;
  endtask

  task automatic test_ack_outside();
    int r0;
    r0 = resp_cnt;
    ack_force = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    total_cnt++;
    if (resp_cnt != r0 || busy !== 1'b0 || vme_cmd_rd !== 1'b1)
      $display("FAIL ack_outside got=%0d/%b/%b expected=0/0/1", resp_cnt - r0, busy, vme_cmd_rd);
    else pass_cnt++;
    ack_force = 1'b0;
    @(negedge clk); #1;
    issue_cmd(32'h02A80099, 32'h0, 2, 16'h0F0F, 1'b0, 1'b0, 16'h0F0F, 2, "after_ack");
  endtask

  task automatic test_back_to_back();
    int r0;
    int i;
    int w;
    @(negedge clk); #1;
    vme_cmd_reg = 32'h02A80010;
    ack_after_v = 1;
    rdata_v = 16'h1111;
    for (int n = 0; n < 3; n++) begin
      exp_q.push_back(mk_exp(1'b0, 1'b0, txn_model, 16'h1111));
      txn_model = txn_model + 8'd1;
    end
    r0 = resp_cnt;
    start = 1'b1;
    i = 0;
    while (resp_cnt < r0 + 3 && i < 100) begin @(negedge clk); #1; i++; end
    start = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    total_cnt++;
    if (resp_cnt != r0 + 3) $display("FAIL b2b_count got=%0d expected=3", resp_cnt - r0);
    else pass_cnt++;
    w = wr_times.size();
    total_cnt++;
    if (w < 3 || wr_times[w-1] - wr_times[w-2] != 4 + GAP || wr_times[w-2] - wr_times[w-3] != 4 + GAP)
      $display("FAIL b2b_spacing got=%0d expected=%0d", (w < 2) ? 0 : wr_times[w-1] - wr_times[w-2], 4 + GAP);
    else pass_cnt++;
    total_cnt++;
    if (last_low_run != 3 + GAP) $display("FAIL b2b_ready_low got=%0d expected=%0d", last_low_run, 3 + GAP);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_strobe();
    int r0;
    int i;
    vme_cmd_reg = 32'h02A85555;
    ack_after_v = 0;
    exp_q.push_back(mk_exp(1'b0, 1'b1, txn_model, 16'h0));
    r0 = resp_cnt;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    i = 0;
    while (!bus_strobe && i < 20) begin @(negedge clk); #1; i++; end
    total_cnt++;
    if (!bus_strobe) $display("FAIL midrst_strobe_start got=0 expected=1");
    else pass_cnt++;
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({bus_strobe, vme_cmd_rd, busy} !== 3'b010)
      $display("FAIL midrst_async got=%b expected=010", {bus_strobe, vme_cmd_rd, busy});
    else pass_cnt++;
    exp_q.delete();
    txn_model = 8'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    total_cnt++;
    if (resp_cnt != r0 || vme_cmd_rd !== 1'b1)
      $display("FAIL midrst_no_resp got=%0d/%b expected=0/1", resp_cnt - r0, vme_cmd_rd);
    else pass_cnt++;
  endtask

  task automatic test_txn_count();
    logic [15:0] a;
    logic [15:0] rd;
    for (int n = 0; n < 257; n++) begin
      a = 16'(n);
      rd = 16'(n * 3 + 1);
      issue_cmd({16'h02A8, a}, 32'h0, 1 + (n % 3), rd, 1'b0, 1'b0, rd, 1 + (n % 3), "txn");
    end
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL txn_drain got=%0d expected=0", exp_q.size());
    else pass_cnt++;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=stuck expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read();
    test_write();
    test_timeout();
    test_invalid();
    test_hold();
    test_ack_outside();
    test_back_to_back();
    test_reset_mid_strobe();
    test_txn_count();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/vme_cmd_executor.md
Name: vme_cmd_executor

Overview:
- Responder end of the simulation command channel: accepts one VME-style command word plus data from the command-file driver, runs a single register-bus read or write cycle, then returns a response word with a one-cycle valid strobe.
- Sits between the command-file driver and the internal register bus decoder.
- Paces the driver through a level "ready for next command" output.

Parameters:
- TIMEOUT_CYC, 255: bus cycles to wait for bus_ack before aborting (1..65535).
- GAP_CYC, 2: idle cycles after each response before ready reasserts (0..15).
- CMD_MASK, 32'h00A80000: bits that must all be set in a valid command word.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous active-high reset
- start  in  1  command valid; sampled only while vme_cmd_rd=1
- vme_cmd_reg  in  32  command: [25] read, [24] write, CMD_MASK bits, [15:0] register address
- vme_dat_reg_in  in  32  write data; [15:0] used
- vme_cmd_rd  out  1  ready for next command (level)
- vme_dat_wr  out  1  one-cycle response strobe
- vme_dat_reg_out  out  32  response word
- bus_addr  out  16  register address
- bus_wdata  out  16  register write data
- bus_rnw  out  1  1=read, 0=write
- bus_strobe  out  1  cycle request, held until ack or timeout
- bus_ack  in  1  cycle complete
- bus_rdata  in  16  read data, valid with bus_ack
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, asserts immediately): state=IDLE. vme_cmd_rd=1. vme_dat_wr=0, vme_dat_reg_out=0, bus_addr=0, bus_wdata=0, bus_rnw=1, bus_strobe=0, busy=0. Timeout and gap counters=0.
- FSM states: IDLE, DECODE, STROBE, RESPOND, HOLDOFF.
- IDLE:
  - vme_cmd_rd=1.
  - start=1 at an edge: latch cmd/data, go to DECODE, vme_cmd_rd=0 from the next cycle.
  - start=0: stay in IDLE.
- DECODE:
  - Valid if (cmd & CMD_MASK)==CMD_MASK and exactly one of [25],[24] is set.
  - Valid: load bus_addr=cmd[15:0], bus_wdata=data[15:0], bus_rnw=cmd[25]; go to STROBE.
  - Invalid: no bus cycle; set error flag; go to RESPOND.
- STROBE:
  - bus_strobe=1; timeout counter increments each cycle.
  - bus_ack=1: capture bus_rdata (read) or echo bus_wdata (write); drop strobe; go to RESPOND.
  - Counter reaches TIMEOUT_CYC with no ack: drop strobe; set timeout flag; data=16'h0000; go to RESPOND.
  - Ack and timeout in the same cycle: ack wins.
- RESPOND (exactly one cycle):
  - vme_dat_wr=1.
  - vme_dat_reg_out={error, timeout, 14'b0, data16}.
  - vme_dat_reg_out holds its value until the next RESPOND or reset.
  - Go to HOLDOFF, or straight to IDLE when GAP_CYC=0.
- HOLDOFF: counts GAP_CYC cycles, then IDLE.
- Latency, valid read with ack on the first strobe cycle:
  - start at edge N, DECODE at N+1, strobe high from N+2.
  - Ack seen at N+2, vme_dat_wr high during N+3.
  - vme_cmd_rd back high at N+4+GAP_CYC.
- Commands and acks outside their states:
  - start while vme_cmd_rd=0 is ignored; never queued.
  - bus_ack outside STROBE is ignored.
- Reset mid-cycle: strobe drops immediately; no response is emitted for the aborted command.

Optional Feature:
- Macro: VME_TXN_COUNT_EN.
- Defined:
  - 8-bit transaction counter, reset 0, increments on every RESPOND and wraps 255 to 0.
  - Response bits [23:16] carry the counter value before the increment, so the first response after reset reads 0.
  - Bits [29:24] stay 0.
- Undefined: no counter logic; bits [29:16] are 0.

Test Plan:
- Read, ack on first strobe cycle: cmd=32'h02A81234, bus_rdata=16'hBEEF -> bus_addr=16'h1234, bus_rnw=1, vme_dat_wr pulse one cycle at N+3, vme_dat_reg_out=32'h0000BEEF.
- Write, ack after 5 cycles: cmd=32'h01A84000, data=32'h00005A5A -> bus_wdata=16'h5A5A, bus_rnw=0, strobe high 5 cycles, response=32'h00005A5A.
- Timeout: read with no ack, TIMEOUT_CYC=8 -> strobe high 8 cycles, then response=32'h40000000.
- Invalid command: cmd=32'h03001234 (both direction bits set, mask clear) -> no bus_strobe, response=32'h80000000.
- Pacing: start held high continuously with GAP_CYC=2 -> exactly one command per response, vme_cmd_rd low from N+1 to N+5; reset asserted mid-STROBE -> bus_strobe=0 asynchronously, no vme_dat_wr, vme_cmd_rd=1.
- VME_TXN_COUNT_EN defined: 257 sequential reads -> bits [23:16] read 0..255, then 0 on response 257.
